// File: rtl/imm_gen_if.sv
// imm_gen_if: fetch->decode handshake bundle for imm_gen_pipe.
//   in_valid/in_ready/inst        : instruction stream into the block
//   out_valid/out_ready           : decoded-immediate stream out of the block
//   imm/fmt/illegal               : decoded payload (imm is XLEN wide)
// slave modport is the block side; master modport is the producer/consumer side.
interface imm_gen_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;

    modport slave (
        input  in_valid, inst, out_ready,
        output in_ready, out_valid, imm, fmt, illegal
    );

    modport master (
        output in_valid, inst, out_ready,
        input  in_ready, out_valid, imm, fmt, illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with a 2-entry skid buffer.
//   clk   : clock, all state on rising edge
//   rst   : asynchronous active-high reset
//   flush : synchronous discard of all buffered entries (wins over accept)
//   bus   : imm_gen_if.slave - in_valid/in_ready/inst in, out_valid/out_ready/imm/fmt/illegal out
// fmt encoding: 0=none 1=I 2=S 3=B 4=U 5=J 6=SHIFT. Latency 1, throughput 1/cycle.
module imm_gen_pipe #(
    parameter int unsigned XLEN   = 64,
    parameter bit          RV64_W = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    imm_gen_if.slave  bus
);
    localparam logic [2:0] FmtNone  = 3'd0;
    localparam logic [2:0] FmtI     = 3'd1;
    localparam logic [2:0] FmtS     = 3'd2;
    localparam logic [2:0] FmtB     = 3'd3;
    localparam logic [2:0] FmtU     = 3'd4;
    localparam logic [2:0] FmtJ     = 3'd5;
    localparam logic [2:0] FmtShift = 3'd6;

    // OP-IMM-32 only exists on RV64 builds that enable it.
    localparam bit WEn = RV64_W && (XLEN == 64);

    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_ill;
    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic            w_is_shift;

    assign w_opc      = bus.inst[6:0];
    assign w_f3       = bus.inst[14:12];
    assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    // Every sign extension replicates inst[31] directly.
    always_comb begin
        w_imm = '0;
        w_fmt = FmtNone;
        w_ill = 1'b1;
        case (w_opc)
            7'b0000011, 7'b1100111: begin
                w_imm = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:20]};
                w_fmt = FmtI;
                w_ill = 1'b0;
            end
            7'b0010011: begin
                w_ill = 1'b0;
                if (w_is_shift) begin
                    w_fmt = FmtShift;
                    if (XLEN == 64) begin
                        w_imm = {{(XLEN-6){1'b0}}, bus.inst[25:20]};
                    end else begin
                        w_imm = {{(XLEN-5){1'b0}}, bus.inst[24:20]};
                        w_ill = bus.inst[25];
                    end
                end else begin
                    w_imm = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:20]};
                    w_fmt = FmtI;
                end
            end
            7'b0011011: begin
                if (WEn && (w_f3 == 3'b000)) begin
                    w_imm = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:20]};
                    w_fmt = FmtI;
                    w_ill = 1'b0;
                end else if (WEn && w_is_shift) begin
                    // Word shifts only have a 5-bit shamt.
                    w_imm = {{(XLEN-5){1'b0}}, bus.inst[24:20]};
                    w_fmt = FmtShift;
                    w_ill = bus.inst[25];
                end
            end
            7'b0100011: begin
                w_imm = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
                w_fmt = FmtS;
                w_ill = 1'b0;
            end
            7'b1100011: begin
                w_imm = {{(XLEN-13){bus.inst[31]}}, bus.inst[31], bus.inst[7],
                         bus.inst[30:25], bus.inst[11:8], 1'b0};
                w_fmt = FmtB;
                w_ill = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                w_imm = {{(XLEN-20){bus.inst[31]}}, bus.inst[31:12]} << 12;
                w_fmt = FmtU;
                w_ill = 1'b0;
            end
            7'b1101111: begin
                w_imm = {{(XLEN-21){bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                         bus.inst[20], bus.inst[30:21], 1'b0};
                w_fmt = FmtJ;
                w_ill = 1'b0;
            end
            default: ;
        endcase
    end

    logic            r_main_valid;
    logic [XLEN-1:0] r_main_imm;
    logic [2:0]      r_main_fmt;
    logic            r_main_ill;
    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_imm;
    logic [2:0]      r_skid_fmt;
    logic            r_skid_ill;
    logic            r_in_ready;

    logic w_accept;
    logic w_drain;
    logic w_main_load;
    logic w_skid_valid_d;

    assign w_accept    = bus.in_valid && r_in_ready && !flush;
    assign w_drain     = r_main_valid && bus.out_ready;
    assign w_main_load = !r_main_valid || w_drain;
    // Skid only fills when main is occupied and stays occupied; it empties whenever main loads.
    assign w_skid_valid_d = r_skid_valid ? !w_main_load : (w_accept && !w_main_load);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_imm   <= '0;
            r_main_fmt   <= FmtNone;
            r_main_ill   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_fmt   <= FmtNone;
            r_skid_ill   <= 1'b0;
            r_in_ready   <= 1'b1;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_main_imm   <= '0;
            r_main_fmt   <= FmtNone;
            r_main_ill   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_fmt   <= FmtNone;
            r_skid_ill   <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            if (w_main_load) begin
                if (r_skid_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_imm   <= r_skid_imm;
                    r_main_fmt   <= r_skid_fmt;
                    r_main_ill   <= r_skid_ill;
                end else begin
                    r_main_valid <= w_accept;
                    if (w_accept) begin
                        r_main_imm <= w_imm;
                        r_main_fmt <= w_fmt;
                        r_main_ill <= w_ill;
                    end
                end
            end
            if (!r_skid_valid && w_skid_valid_d) begin
                r_skid_imm <= w_imm;
                r_skid_fmt <= w_fmt;
                r_skid_ill <= w_ill;
            end
            r_skid_valid <= w_skid_valid_d;
            r_in_ready   <= !w_skid_valid_d;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_main_valid;
    assign bus.imm       = r_main_imm;
    assign bus.fmt       = r_main_fmt;
    assign bus.illegal   = r_main_ill;
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the decode stage. It replaces the combinational immediate path with one that supports XLEN 32 or 64 and every RV base immediate format (I, S, B, U, J, shift). It also flags unsupported opcodes. A valid/ready handshake and a 2-entry skid buffer sit between fetch and decode, so it sustains one instruction per cycle under backpressure.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
RV64_W, 1, when 1 and XLEN=64, OP-IMM-32 (0011011) is decoded; otherwise it is illegal.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous; discards all buffered entries
in_valid  input  1  inst is presented
in_ready  output  1  block can accept inst this cycle
inst  input  32  instruction word
out_valid  output  1  imm/fmt/illegal valid
out_ready  input  1  consumer accepts this cycle
imm  output  XLEN  sign/zero-extended immediate
fmt  output  3  0=none 1=I 2=S 3=B 4=U 5=J 6=SHIFT
illegal  output  1  opcode/shamt not supported

Behaviour:
- Reset (async, rst=1): both buffer entries empty, out_valid=0, in_ready=1, imm=0, fmt=0, illegal=0. Reset mid-transfer drops all entries with no partial output.
- Decode is combinational on inst and is written into the main register on an accepted input (in_valid & in_ready). Latency is 1 cycle: an accepted inst is on the outputs the next cycle.
- I format: opcode 0000011, 1100111, 0010011 with funct3 not 001/101, and 0011011 (funct3 000) when enabled. imm = sext(inst[31:20]).
- S format: opcode 0100011. imm = sext({inst[31:25],inst[11:7]}).
- B format: opcode 1100011. imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
- U format: opcode 0110111 and 0010111. imm = sext({inst[31:12],12'b0}); for XLEN=32 no extension is needed.
- J format: opcode 1101111. imm = sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
- SHIFT format: opcode 0010011 with funct3 001/101. imm = zext(shamt).
  - XLEN=64: shamt = inst[25:20].
  - XLEN=32: shamt = inst[24:20], and inst[25]=1 sets illegal.
  - OP-IMM-32 shifts: shamt = inst[24:20], and inst[25]=1 sets illegal.
- Sign extension is always taken from the instruction bit (inst[31]), never from a partially built result.
- Any other opcode: fmt=0, imm=0, illegal=1. Illegal entries still flow through the handshake in order.
- Skid buffer, 2 entries: main register plus skid register.
  - in_ready is registered and equals !skid_full.
  - If the main register is full, out_ready=0, and an input is accepted, the input goes to the skid register.
  - When the main register drains, the skid register moves to main in the same cycle.
  - Order is strictly preserved.
- Simultaneous accept and drain on a full main register with an empty skid: the new entry replaces main directly, with no bubble.
- Outputs hold stable while out_valid=1 & out_ready=0.
- flush: both entries are cleared next edge and out_valid=0. An input presented in the same cycle is discarded. flush has priority over accept.
- Throughput: 1 per cycle when out_ready is held at 1.

Test Plan:
- XLEN=64: inst 0xFFF00093 (addi x1,x0,-1) → next cycle imm=0xFFFFFFFFFFFFFFFF, fmt=1, illegal=0. Inst 0xFE112E23 (sw x1,-4(x2)) → imm=0xFFFFFFFFFFFFFFFC, fmt=2.
- XLEN=64: inst 0xFE000CE3 (beq -8) → imm=0xFFFFFFFFFFFFFFF8, fmt=3. Inst 0x800000B7 (lui 0x80000) → imm=0xFFFFFFFF80000000, fmt=4.
- Inst 0x03F09093 (slli x1,x1,63): XLEN=64 → imm=63, fmt=6, illegal=0. XLEN=32 → illegal=1. Inst 0x0000007F → fmt=0, imm=0, illegal=1.
- Backpressure: out_ready=0 for 3 cycles while feeding A,B,C back-to-back.
  - A and B are accepted; in_ready falls after B; C is held.
  - Raise out_ready: outputs A,B,C on consecutive cycles, none lost or duplicated.
- Streaming: 16 random legal insts with out_ready=1 → 16 outputs on consecutive cycles, each matching a reference decoder.
- Assert flush with 2 entries buffered → next cycle out_valid=0, in_ready=1. Assert rst asynchronously mid-stream → outputs clear immediately without waiting for clk.
